// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the two register-file producers, the arbiter and the decode bypass.
// master = producer/decode side, slave = the arbiter.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              aluValid;
  logic [REG_W-1:0]  aluReg;
  logic [DATA_W-1:0] aluData;
  logic              aluReady;
  logic              memValid;
  logic [REG_W-1:0]  memReg;
  logic [DATA_W-1:0] memData;
  logic              memReady;
  logic              regWr;
  logic [REG_W-1:0]  wrReg;
  logic [DATA_W-1:0] wrData;
  logic [REG_W-1:0]  rdReg1;
  logic [REG_W-1:0]  rdReg2;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] fwdData1;
  logic [DATA_W-1:0] fwdData2;
  logic [CNT_W-1:0]  conflictCnt;

  modport master (
    output aluValid, aluReg, aluData, memValid, memReg, memData, rdReg1, rdReg2,
    input  aluReady, memReady, regWr, wrReg, wrData, fwd1, fwd2, fwdData1, fwdData2,
           conflictCnt
  );

  modport slave (
    input  aluValid, aluReg, aluData, memValid, memReg, memData, rdReg1, rdReg2,
    output aluReady, memReady, regWr, wrReg, wrData, fwd1, fwd2, fwdData1, fwdData2,
           conflictCnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU vs load return),
// with a registered write stage, a decode bypass and a saturating conflict counter.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic           iClk,
  input logic           iRst,
  rf_wb_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } stateT;

  stateT             state;
  logic              lastGrant;   // 0 = ALU, 1 = MEM
  logic [REG_W-1:0]  wrReg;
  logic [DATA_W-1:0] wrData;
  logic [CNT_W-1:0]  conflictCnt;

  logic              aluGrant;
  logic              memGrant;
  logic              accept;
  logic              conflict;
  logic [REG_W-1:0]  winReg;
  logic [DATA_W-1:0] winData;
  logic              regWr;

  assign conflict = bus.aluValid && bus.memValid;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    aluGrant = 1'b0;
    memGrant = 1'b0;
    if (conflict) begin
      aluGrant = lastGrant;
      memGrant = !lastGrant;
    end else begin
      aluGrant = bus.aluValid;
      memGrant = bus.memValid;
    end
  end

  assign accept  = aluGrant || memGrant;
  assign winReg  = memGrant ? bus.memReg  : bus.aluReg;
  assign winData = memGrant ? bus.memData : bus.aluData;

  // NOTE: state is written only with non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      lastGrant   <= 1'b1;
      wrReg       <= '0;
      wrData      <= '0;
      conflictCnt <= '0;
    end else begin
      if (accept) begin
        state     <= WRITE;
        wrReg     <= winReg;
        wrData    <= winData;
        lastGrant <= memGrant;
      end else begin
        state     <= IDLE;
      end
      if (conflict && (conflictCnt != {CNT_W{1'b1}})) begin
        conflictCnt <= conflictCnt + 1'b1;
      end
    end
  end

  // A reg-0 write still occupies the WRITE slot but never strobes the array.
  assign regWr = (state == WRITE) && (wrReg != '0);

  assign bus.aluReady    = aluGrant;
  assign bus.memReady    = memGrant;
  assign bus.regWr       = regWr;
  assign bus.wrReg       = wrReg;
  assign bus.wrData      = wrData;
  assign bus.conflictCnt = conflictCnt;

  assign bus.fwd1     = regWr && (wrReg == bus.rdReg1);
  assign bus.fwd2     = regWr && (wrReg == bus.rdReg2);
  assign bus.fwdData1 = bus.fwd1 ? wrData : '0;
  assign bus.fwdData2 = bus.fwd2 ? wrData : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares whenever the register-file strobe is high.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } wrT;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  wrT   expQ[$];

  always #5 iClk = ~iClk;

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, check the combinational readies, enqueue the expected write,
  // then advance to just after the next rising edge.
  task automatic step(input logic aV, input logic [REG_W-1:0] aR, input logic [DATA_W-1:0] aD,
                      input logic mV, input logic [REG_W-1:0] mR, input logic [DATA_W-1:0] mD,
                      input logic eA, input logic eM, input string tag);
    wrT e;
    bus.aluValid = aV;
    bus.aluReg   = aR;
    bus.aluData  = aD;
    bus.memValid = mV;
    bus.memReg   = mR;
    bus.memData  = mD;
    #1;
    check({tag, "_alu_ready"}, 64'(bus.aluReady), 64'(eA));
    check({tag, "_mem_ready"}, 64'(bus.memReady), 64'(eM));
    if (eA && aR != '0) begin
      e.r = aR; e.d = aD; expQ.push_back(e);
    end
    if (eM && mR != '0) begin
      e.r = mR; e.d = mD; expQ.push_back(e);
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: every strobed write must match the oldest expected write.
  initial begin
    wrT e;
    forever begin
      @(negedge iClk);
      if (bus.regWr === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got reg %0d data 0x%0h, required no write (t=%0t)",
                   bus.wrReg, bus.wrData, $time);
        end else begin
          e = expQ.pop_front();
          check("wr_reg",  64'(bus.wrReg),  64'(e.r));
          check("wr_data", 64'(bus.wrData), 64'(e.d));
        end
      end
    end
  end

  initial begin
    bus.aluValid = 1'b0; bus.aluReg = '0; bus.aluData = '0;
    bus.memValid = 1'b0; bus.memReg = '0; bus.memData = '0;
    bus.rdReg1   = '0;   bus.rdReg2 = '0;
    iRst = 1'b1;
    @(posedge iClk); #1;

    // Readies follow arbitration during reset, but nothing is accepted.
    bus.aluValid = 1'b1; bus.aluReg = 5'd3; bus.aluData = 32'hDEAD;
    #1;
    check("rst_alu_ready", 64'(bus.aluReady), 64'd1);
    check("rst_mem_ready", 64'(bus.memReady), 64'd0);
    @(posedge iClk); #1;
    check("rst_regwr",    64'(bus.regWr),       64'd0);
    check("rst_wrreg",    64'(bus.wrReg),       64'd0);
    check("rst_wrdata",   64'(bus.wrData),      64'd0);
    check("rst_cnt",      64'(bus.conflictCnt), 64'd0);
    check("rst_fwd1",     64'(bus.fwd1),        64'd0);
    check("rst_fwddata1", 64'(bus.fwdData1),    64'd0);
    bus.aluValid = 1'b0;
    iRst = 1'b0;

    // Continuous conflict straight after reset: ALU, MEM, ALU, MEM.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, "rr0");
    step(1'b1, 5'd1, 32'h13, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, "rr1");
    step(1'b1, 5'd1, 32'h13, 1'b1, 5'd2, 32'h24, 1'b1, 1'b0, "rr2");
    step(1'b1, 5'd1, 32'h15, 1'b1, 5'd2, 32'h24, 1'b0, 1'b1, "rr3");
    check("rr_cnt", 64'(bus.conflictCnt), 64'd4);

    // Single ALU write, one-cycle strobe.
    step(1'b1, 5'd3, 32'h1234, 1'b0, '0, '0, 1'b1, 1'b0, "alu1");
    idle("alu1_wr");
    check("alu1_strobe_drop", 64'(bus.regWr), 64'd0);

    // A lone load leaves lastGrant = MEM, so the ALU wins the same-register conflict.
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, "mem1");
    step(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 1'b1, 1'b0, "same0");
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hB, 1'b0, 1'b1, "same1");
    idle("same_wr");

    // Register 0: granted but never written nor bypassed.
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b1, 1'b0, "reg0");
    bus.rdReg1 = 5'd0;
    #1;
    check("reg0_regwr", 64'(bus.regWr), 64'd0);
    check("reg0_fwd1",  64'(bus.fwd1),  64'd0);

    // Bypass of an in-flight write to reg 7.
    step(1'b1, 5'd7, 32'h55, 1'b0, '0, '0, 1'b1, 1'b0, "byp");
    bus.rdReg1 = 5'd6;
    bus.rdReg2 = 5'd7;
    #1;
    check("byp_fwd2",     64'(bus.fwd2),     64'd1);
    check("byp_fwddata2", 64'(bus.fwdData2), 64'h55);
    check("byp_fwd1",     64'(bus.fwd1),     64'd0);
    check("byp_fwddata1", 64'(bus.fwdData1), 64'd0);
    bus.rdReg1 = '0;
    bus.rdReg2 = '0;

    // Reset the cycle after an accept: pending write drops, ALU wins the next conflict.
    step(1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b1, 1'b0, "racc");
    iRst = 1'b1;
    bus.aluValid = 1'b0;
    @(posedge iClk); #1;
    check("mid_rst_regwr", 64'(bus.regWr),       64'd0);
    check("mid_rst_cnt",   64'(bus.conflictCnt), 64'd0);
    iRst = 1'b0;
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, "post0");
    step(1'b0, '0, '0, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1, "post1");
    idle("post_wr");

    // Long conflict on reg 0: strict alternation and counter saturation at 15.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i), (i % 2) == 0, (i % 2) == 1, "sat");
    end
    check("sat_cnt", 64'(bus.conflictCnt), 64'd15);
    idle("tail0");
    idle("tail1");
    check("queue_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
